// File: rtl/scan_pkg.sv
// Shared definitions for the scan sequencer and its bench.
package scan_pkg;

    typedef enum logic [1:0] {
        st_idle   = 2'd0,
        st_active = 2'd1,
        st_blank  = 2'd2
    } scan_state_t;

    localparam int unsigned BLANK_CYCLES_DEF = 1;
    localparam int unsigned BLANK_W          = 4;

endpackage

// File: rtl/scan_sequencer_dwell_counter.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module dwell_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Steps a 3-bit decoder select through indices 0..7 with a dwell period
// (enable high) and a blanking gap (enable low) between steps.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int unsigned DWELL_W      = 8,
    parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               single,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               e,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    scan_state_t        state, state_nx;
    logic [2:0]         idx, idx_nx;
    logic [DWELL_W-1:0] dwell_lat, dwell_lat_nx;
    logic               single_lat, single_lat_nx;
    logic               e_q, wrap_q, wrap_nx;

    logic               dw_load, dw_dec, dw_zero;
    logic [DWELL_W-1:0] dw_val, dwell_m1;
    logic               bk_load, bk_dec, bk_zero;
    logic [BLANK_W-1:0] bk_val;

    // Counters hold "cycles remaining minus one", so a zero dwell becomes 1 cycle.
    always_comb begin
        dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    end

    dwell_counter #(.W(DWELL_W)) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dw_load),
        .load_val (dw_val),
        .dec      (dw_dec),
        .zero     (dw_zero)
    );

    dwell_counter #(.W(BLANK_W)) u_blank (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bk_load),
        .load_val (bk_val),
        .dec      (bk_dec),
        .zero     (bk_zero)
    );

    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        dwell_lat_nx  = dwell_lat;
        single_lat_nx = single_lat;
        wrap_nx       = 1'b0;
        dw_load       = 1'b0;
        dw_val        = '0;
        dw_dec        = 1'b0;
        bk_load       = 1'b0;
        bk_val        = '0;
        bk_dec        = 1'b0;

        unique case (state)
            st_idle: begin
                if (start) begin
                    state_nx      = st_active;
                    idx_nx        = 3'd0;
                    dwell_lat_nx  = dwell_m1;
                    single_lat_nx = single;
                    dw_load       = 1'b1;
                    dw_val        = dwell_m1;
                end
            end
            st_active: begin
                if (dw_zero) begin
                    // Index advances together with e falling, never while e is high.
                    state_nx = st_blank;
                    idx_nx   = idx + 3'd1;
                    wrap_nx  = (idx == 3'd7) && !single_lat;
                    bk_load  = 1'b1;
                    bk_val   = BLANK_W'(BLANK_CYCLES - 1);
                end else begin
                    dw_dec = 1'b1;
                end
            end
            st_blank: begin
                if (bk_zero) begin
                    if ((idx == 3'd0) && single_lat) begin
                        state_nx = st_idle;
                    end else begin
                        state_nx = st_active;
                        dw_load  = 1'b1;
                        dw_val   = dwell_lat;
                    end
                end else begin
                    bk_dec = 1'b1;
                end
            end
            default: begin
                state_nx = st_idle;
                idx_nx   = 3'd0;
            end
        endcase

        if (stop) begin
            state_nx = st_idle;
            idx_nx   = 3'd0;
            wrap_nx  = 1'b0;
            dw_load  = 1'b1;
            dw_val   = '0;
            bk_load  = 1'b1;
            bk_val   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= st_idle;
            idx        <= 3'd0;
            dwell_lat  <= '0;
            single_lat <= 1'b0;
            e_q        <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            dwell_lat  <= dwell_lat_nx;
            single_lat <= single_lat_nx;
            e_q        <= (state_nx == st_active);
            wrap_q     <= wrap_nx;
        end
    end

    assign a    = idx[2];
    assign b    = idx[1];
    assign c    = idx[0];
    assign e    = e_q;
    assign busy = (state != st_idle);
    assign wrap = wrap_q;
    // Final blank cycle of a single pass: index has already wrapped back to 0.
    assign done = (state == st_blank) && bk_zero && (idx == 3'd0) && single_lat;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: stimulus queues expected outputs, a negedge monitor checks them.
module tb_scan_sequencer;
    import scan_pkg::*;

    typedef struct {
        logic [2:0] sel;
        logic       e;
        logic       busy;
        logic       done;
        logic       wrap;
        string      tag;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       single;
    logic [7:0] dwell;
    logic       a, b, c, e, busy, done, wrap;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    logic       prev_e;
    logic [2:0] prev_sel;

    scan_sequencer #(
        .DWELL_W      (8),
        .BLANK_CYCLES (BLANK_CYCLES_DEF)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .single (single),
        .dwell  (dwell),
        .a      (a),
        .b      (b),
        .c      (c),
        .e      (e),
        .busy   (busy),
        .done   (done),
        .wrap   (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t idle_exp(input string tag);
        exp_t x;
        x.sel  = 3'd0;
        x.e    = 1'b0;
        x.busy = 1'b0;
        x.done = 1'b0;
        x.wrap = 1'b0;
        x.tag  = tag;
        return x;
    endfunction

    // Closed-form expectation for cycle k after the start edge (k=1 is the first ACTIVE cycle).
    function automatic exp_t scan_exp(input int unsigned dw, input bit sgl,
                                      input int unsigned k, input string tag);
        exp_t x;
        int unsigned d, p, j, i, ph;
        d  = (dw == 0) ? 1 : dw;
        p  = d + BLANK_CYCLES_DEF;
        j  = k - 1;
        i  = j / p;
        ph = j % p;
        if (sgl && (j >= 8 * p)) begin
            x = idle_exp("");
        end else begin
            x.busy = 1'b1;
            x.e    = (ph < d);
            x.sel  = (ph < d) ? 3'(i % 8) : 3'((i + 1) % 8);
            x.wrap = !sgl && ((i % 8) == 7) && (ph == d);
            x.done = sgl && (i == 7) && (ph == p - 1);
        end
        x.tag = $sformatf("%s k=%0d", tag, k);
        return x;
    endfunction

    // Drive inputs sampled at the next edge, then queue the output expected after it.
    task automatic cyc(input logic r, input logic s, input logic p, input exp_t x);
        rst_n = r;
        start = s;
        stop  = p;
        @(posedge clk);
        #1;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            logic [2:0] sel;
            x   = exp_q.pop_front();
            sel = {a, b, c};
            checks++;
            if (sel !== x.sel || e !== x.e || busy !== x.busy ||
                done !== x.done || wrap !== x.wrap) begin
                errors++;
                $display("FAIL %s: got sel=%0d e=%b busy=%b done=%b wrap=%b, want sel=%0d e=%b busy=%b done=%b wrap=%b",
                         x.tag, sel, e, busy, done, wrap, x.sel, x.e, x.busy, x.done, x.wrap);
            end
            if (e === 1'b1 && prev_e === 1'b1) begin
                checks++;
                if (sel !== prev_sel) begin
                    errors++;
                    $display("FAIL sel_stable_while_e %s: got sel=%0d, want sel=%0d", x.tag, sel, prev_sel);
                end
            end
        end
        prev_e   = e;
        prev_sel = {a, b, c};
    end

    initial begin
        checks   = 0;
        errors   = 0;
        prev_e   = 1'b0;
        prev_sel = 3'd0;
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        single   = 1'b0;
        dwell    = 8'd0;

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, idle_exp("reset"));

        // Start and stop together: stop wins.
        cyc(1'b1, 1'b1, 1'b1, idle_exp("start_stop_idle"));
        cyc(1'b1, 1'b0, 1'b0, idle_exp("idle_after_start_stop"));

        // Single pass, dwell=3; mid-scan input changes and a stray start are ignored.
        dwell  = 8'd3;
        single = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, scan_exp(3, 1, 1, "single"));
        for (int m = 1; m < 34; m++) begin
            if (m == 5) dwell = 8'd7;
            if (m == 6) single = 1'b0;
            cyc(1'b1, (m == 10), 1'b0, scan_exp(3, 1, m + 1, "single"));
        end

        // Continuous, dwell=2: runs through the wrap, aborted while at index 5.
        dwell  = 8'd2;
        single = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, scan_exp(2, 0, 1, "cont"));
        for (int m = 1; m < 40; m++) cyc(1'b1, 1'b0, 1'b0, scan_exp(2, 0, m + 1, "cont"));
        cyc(1'b1, 1'b0, 1'b1, idle_exp("abort_idx5"));
        cyc(1'b1, 1'b0, 1'b0, idle_exp("after_abort"));
        cyc(1'b1, 1'b0, 1'b0, idle_exp("after_abort"));

        // Zero dwell behaves as one cycle; reset lands during an ACTIVE cycle.
        dwell  = 8'd0;
        single = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, scan_exp(0, 1, 1, "dwell0"));
        for (int m = 1; m < 7; m++) cyc(1'b1, 1'b0, 1'b0, scan_exp(0, 1, m + 1, "dwell0"));
        cyc(1'b0, 1'b1, 1'b0, idle_exp("mid_scan_reset"));

        // First edge after reset release accepts a start.
        dwell = 8'd4;
        cyc(1'b1, 1'b1, 1'b0, scan_exp(4, 1, 1, "start_after_reset"));
        cyc(1'b1, 1'b0, 1'b0, scan_exp(4, 1, 2, "start_after_reset"));
        cyc(1'b1, 1'b0, 1'b1, idle_exp("final_stop"));
        cyc(1'b1, 1'b0, 1'b0, idle_exp("final_idle"));

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter DWELL_W, default 8: width of the dwell count input.
REQ-002 Parameter BLANK_CYCLES, default 1: number of enable-low cycles between select steps, legal range 1..15.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port start, input, 1: level sampled each cycle; launches a scan when idle.
REQ-006 Port stop, input, 1: abort request; stops the scan.
REQ-007 Port single, input, 1: mode select; 1 = one pass of indices 0..7, 0 = continuous.
REQ-008 Port dwell, input, DWELL_W: number of enable-high cycles per index.
REQ-009 Port a, b, c, output, 1 each: registered 3-bit select; a is the MSB and c is the LSB, for the downstream 3-to-8 decoder.
REQ-010 Port e, output, 1: registered decoder enable.
REQ-011 Port busy, output, 1: high while the scan is in ACTIVE or BLANK.
REQ-012 Port done, output, 1: one-cycle pulse at the end of a single-mode pass.
REQ-013 Port wrap, output, 1: one-cycle pulse when a continuous scan returns from index 7 to index 0.

Function
REQ-014 The FSM SHALL have three states:
- IDLE
- ACTIVE (e=1)
- BLANK (e=0)
REQ-015 start=1 and stop=0 in IDLE at edge N SHALL do all of the following:
- latch dwell and single
- set index to 0
- enter ACTIVE
- drive e=1 and busy=1 from cycle N+1
REQ-016 A latched dwell of 0 SHALL be treated as 1; changes to dwell or single during a scan SHALL have no effect until the next start.
REQ-017 ACTIVE SHALL last exactly the latched dwell cycles, then enter BLANK.
REQ-018 BLANK SHALL last exactly BLANK_CYCLES cycles with e=0; the index SHALL increment on the first BLANK cycle, so {a,b,c} never changes while e=1.
REQ-019 At the end of BLANK, when the index has not wrapped, the FSM SHALL return to ACTIVE.
REQ-020 Index 7 incrementing to 0 in single mode SHALL do both of the following:
- end of BLANK: enter IDLE
- on that IDLE-entry cycle: done=1 for exactly one cycle
REQ-021 Index 7 incrementing to 0 in continuous mode SHALL do both of the following:
- the wrap transition: wrap=1 for one cycle
- end of BLANK: return to ACTIVE at index 0
REQ-022 stop=1 in any state SHALL do all of the following:
- enter IDLE on the next edge
- e=0, busy=0, index=0
- no done and no wrap pulse
REQ-023 When start and stop are both 1 in the same cycle, stop SHALL win.
REQ-024 start while busy SHALL be ignored.
REQ-025 In IDLE, e and busy SHALL be 0 and {a,b,c} SHALL be 3'b000.
REQ-026 The dwell counter SHALL be DWELL_W bits wide, counting down, with no overflow path.

Reset
REQ-027 When rst_n=0 at a rising clk edge, the block SHALL enter IDLE with index=0, dwell counter=0, blank counter=0, and a=b=c=e=busy=done=wrap=0.
REQ-028 Reset SHALL override start and stop and take effect mid-scan on the same edge.
REQ-029 The first start SHALL be accepted on the first edge after rst_n returns high.

Structure
REQ-030 The FSM state encoding and the default BLANK_CYCLES SHALL live in a shared package scan_pkg, used by the sequencer and its bench.
REQ-031 One sub-module, dwell_counter (a loadable down-counter with a zero flag), SHALL be instantiated twice: once for dwell and once for blank.
REQ-032 The 3-to-8 decoder SHALL NOT be instantiated inside this block; it connects externally.

Verification
REQ-033 Single-mode pass: dwell=3, single=1, start pulsed at cycle 0 -> e high on cycles 1-3 with index 0, BLANK at cycle 4, index 1 on cycles 5-7, ..., done=1 on cycle 32, then IDLE.
REQ-034 Continuous wrap: dwell=2, single=0 -> index sequence 0..7,0; wrap=1 on the 7->0 transition; e never high while {a,b,c} changes.
REQ-035 Abort: stop=1 while at index 5 -> next cycle e=0, busy=0, {a,b,c}=000, with no done and no wrap.
REQ-036 Simultaneous start and stop in IDLE -> remains IDLE with busy=0; a start pulse during the scan is ignored.
REQ-037 Zero dwell and mid-scan reset: dwell=0 -> 1-cycle ACTIVE per index; rst_n=0 mid-ACTIVE -> all outputs 0 on the next edge.
REQ-038 Decoder checker: when the decoder is connected downstream, exactly one decoder output is high while e=1, and all decoder outputs are 0 while e=0.
